// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the writeback / register-file slice.
// The write-through bypass in regfile_2r1w is enabled by defining WB_BYPASS_EN.
package pipeline_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int REG_N  = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // A writeback commits only when it targets a real register; r0 is hardwired to zero.
    function automatic logic is_commit(input logic reg_write, input reg_idx_t rd);
        return reg_write && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 2-read / 1-write architectural register file with a hardwired zero register.
// Optional same-cycle write-through bypass when WB_BYPASS_EN is defined.
module regfile_2r1w
    import pipeline_pkg::*;
#(
    parameter int DATA_W = pipeline_pkg::DATA_W,
    parameter int REG_N  = pipeline_pkg::REG_N,
    parameter int ADDR_W = pipeline_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rs_addr,
    input  logic [ADDR_W-1:0] i_rt_addr,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data
);

    logic [DATA_W-1:0] r_regs [REG_N];
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    // Array update: reset clears every entry, entry 0 is never written.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < REG_N; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wr_addr != ADDR_W'(REG_ZERO))) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Read port A: zero index wins over bypass, bypass wins over the array.
    always_comb begin
        w_rs_data = '0;
        if (i_rs_addr == ADDR_W'(REG_ZERO)) begin
            w_rs_data = '0;
        end
`ifdef WB_BYPASS_EN
        else if (i_we && (i_rs_addr == i_wr_addr)) begin
            w_rs_data = i_wr_data;
        end
`endif
        else begin
            w_rs_data = r_regs[i_rs_addr];
        end
    end

    // Read port B: same priority as port A.
    always_comb begin
        w_rt_data = '0;
        if (i_rt_addr == ADDR_W'(REG_ZERO)) begin
            w_rt_data = '0;
        end
`ifdef WB_BYPASS_EN
        else if (i_we && (i_rt_addr == i_wr_addr)) begin
            w_rt_data = i_wr_data;
        end
`endif
        else begin
            w_rt_data = r_regs[i_rt_addr];
        end
    end

    assign o_rs_data = w_rs_data;
    assign o_rt_data = w_rt_data;

endmodule

// File: rtl/wb_regfile_stage.sv
// Writeback stage: selects the writeback value, commits it to the register file,
// and publishes a one-cycle-late forwarding record plus a retired-write counter.
module wb_regfile_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W = pipeline_pkg::DATA_W,
    parameter int REG_N  = pipeline_pkg::REG_N,
    parameter int ADDR_W = pipeline_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] read_data,
    input  logic [ADDR_W-1:0] rd_num,
    input  logic [ADDR_W-1:0] rs_num,
    input  logic [ADDR_W-1:0] rt_num,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd_num,
    output logic [DATA_W-1:0] fwd_data,
    output logic [31:0]       retire_count
);

    logic [DATA_W-1:0] w_wb_data;
    logic              w_we;
    logic              r_fwd_valid;
    logic [ADDR_W-1:0] r_fwd_rd_num;
    logic [DATA_W-1:0] r_fwd_data;
    logic [31:0]       r_retire_count;

    assign w_wb_data = mem_to_reg ? read_data : alu_result;
    assign w_we      = reg_write && (rd_num != ADDR_W'(REG_ZERO));

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_we      (w_we),
        .i_wr_addr (rd_num),
        .i_wr_data (w_wb_data),
        .i_rs_addr (rs_num),
        .i_rt_addr (rt_num),
        .o_rs_data (rs_data),
        .o_rt_data (rt_data)
    );

    // Forwarding record and retire counter; the counter wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_valid    <= 1'b0;
            r_fwd_rd_num   <= '0;
            r_fwd_data     <= '0;
            r_retire_count <= 32'd0;
        end else if (w_we) begin
            r_fwd_valid    <= 1'b1;
            r_fwd_rd_num   <= rd_num;
            r_fwd_data     <= w_wb_data;
            r_retire_count <= r_retire_count + 32'd1;
        end else begin
            r_fwd_valid    <= 1'b0;
            r_fwd_rd_num   <= '0;
            r_fwd_data     <= '0;
            r_retire_count <= r_retire_count;
        end
    end

    assign wb_data      = w_wb_data;
    assign fwd_valid    = r_fwd_valid;
    assign fwd_rd_num   = r_fwd_rd_num;
    assign fwd_data     = r_fwd_data;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Scoreboard bench for wb_regfile_stage: driver pushes expectations from a
// behavioural register-file model, an independent monitor pops and compares.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic        reg_write = 1'b0;
    logic [31:0] alu_result = 32'd0;
    logic [31:0] read_data = 32'd0;
    logic [4:0]  rd_num = 5'd0;
    logic [4:0]  rs_num = 5'd0;
    logic [4:0]  rt_num = 5'd0;
    logic [31:0] rs_data, rt_data, wb_data, fwd_data, retire_count;
    logic        fwd_valid;
    logic [4:0]  fwd_rd_num;

    wb_regfile_stage dut (
        .clk(clk), .rst(rst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_result(alu_result), .read_data(read_data), .rd_num(rd_num),
        .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs_data), .rt_data(rt_data),
        .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_rd_num(fwd_rd_num),
        .fwd_data(fwd_data), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs, rt, wb, fd, cnt;
        logic [4:0]  frd;
        logic        fv;
        bit          known;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   driver_done = 1'b0;

    // Reference state: what the architectural registers hold after the last edge.
    logic [31:0] m_regs [32];
    bit          m_known = 1'b0;
    logic        m_fv = 1'b0;
    logic [4:0]  m_frd = 5'd0;
    logic [31:0] m_fd = 32'd0;
    logic [31:0] m_cnt = 32'd0;

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic we,
                                           input logic [4:0] rd, input logic [31:0] wb);
        if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (we && idx == rd) return wb;
`endif
        return m_regs[idx];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        exp_t        e;
        logic        we;
        logic [31:0] wb;
        @(negedge clk);
        rst = r; reg_write = rw; mem_to_reg = m2r; alu_result = alu;
        read_data = rdat; rd_num = rd; rs_num = rs; rt_num = rt;
        wb = m2r ? rdat : alu;
        we = rw && (rd != 5'd0);
        e.wb = wb; e.known = m_known;
        e.rs = m_read(rs, we, rd, wb);
        e.rt = m_read(rt, we, rd, wb);
        e.fv = m_fv; e.frd = m_frd; e.fd = m_fd; e.cnt = m_cnt;
        exp_q.push_back(e);
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_known = 1'b1; m_fv = 1'b0; m_frd = 5'd0; m_fd = 32'd0; m_cnt = 32'd0;
        end else if (we) begin
            m_regs[rd] = wb; m_fv = 1'b1; m_frd = rd; m_fd = wb; m_cnt = m_cnt + 32'd1;
        end else begin
            m_fv = 1'b0; m_frd = 5'd0; m_fd = 32'd0;
        end
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, rs, rt);
    endtask

    // Monitor: samples mid-cycle, after inputs settle and before the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_data", wb_data, e.wb);
                if (e.known) begin
                    chk("rs_data", rs_data, e.rs);
                    chk("rt_data", rt_data, e.rt);
                    chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, e.fv});
                    chk("fwd_rd_num", {27'd0, fwd_rd_num}, {27'd0, e.frd});
                    chk("fwd_data", fwd_data, e.fd);
                    chk("retire_count", retire_count, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [4:0] rd, rs, rt;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        idle(5'd5, 5'd31);
        drive(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0BAD_0BAD, 5'd7, 5'd7, 5'd1);
        idle(5'd7, 5'd7);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd7);
        drive(1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 32'd0, 5'd9, 5'd9, 5'd9);
        idle(5'd9, 5'd9);
        drive(1'b1, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'd0, 5'd3, 5'd3, 5'd9);
        idle(5'd3, 5'd9);
        idle(5'd1, 5'd3);
        // Deposit a near-wrap counter value between samples and edge.
        #3;
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        m_cnt = 32'hFFFF_FFFF;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0055, 32'd0, 5'd1, 5'd1, 5'd0);
        idle(5'd1, 5'd0);
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) rd = 5'd0;
            rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom, $urandom, rd, rs, rt);
        end
        idle(5'd0, 5'd0);
        repeat (3) @(negedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d expected 0 pending", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Writeback stage of the 5-stage pipeline. Consumes the MEM/WB pipeline-register outputs and selects the writeback value (load data or ALU result).
- Commits that value into the 32-entry architectural register file, which ID reads through two read ports.
- Also drives a registered one-cycle-late forwarding record and a retired-write counter.

Parameters:
- DATA_W, 32, datapath/register width
- REG_N, 32, number of architectural registers
- ADDR_W, 5, register index width (log2 REG_N)

Ports:
- clk  input  1  pipeline clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- mem_to_reg  input  1  from MEM/WB: 1 = write back read_data, 0 = write back alu_result
- reg_write  input  1  from MEM/WB: instruction writes a register
- alu_result  input  DATA_W  from MEM/WB: ALU result
- read_data  input  DATA_W  from MEM/WB: data-memory load value
- rd_num  input  ADDR_W  from MEM/WB: destination register index
- rs_num  input  ADDR_W  ID-stage read index A
- rt_num  input  ADDR_W  ID-stage read index B
- rs_data  output  DATA_W  read data A (combinational)
- rt_data  output  DATA_W  read data B (combinational)
- wb_data  output  DATA_W  selected writeback value (combinational, for EX forwarding)
- fwd_valid  output  1  registered: a write committed last cycle
- fwd_rd_num  output  ADDR_W  registered: index written last cycle
- fwd_data  output  DATA_W  registered: value written last cycle
- retire_count  output  32  count of committed register writes

Behaviour:
- wb_data = mem_to_reg ? read_data : alu_result. Pure mux, zero latency.
- we = reg_write && (rd_num != 0).
- Register r0 is never written and always reads 0.
- Posedge, rst=1:
  - all REG_N entries clear to 0.
  - fwd_valid=0, fwd_rd_num=0, fwd_data=0, retire_count=0.
  - rst dominates: any write presented in the reset cycle is dropped and not counted.
- Posedge, rst=0, we=1:
  - regs[rd_num] <= wb_data.
  - fwd_valid<=1, fwd_rd_num<=rd_num, fwd_data<=wb_data.
  - retire_count <= retire_count+1.
- Posedge, rst=0, we=0:
  - regs unchanged; fwd_valid<=0, fwd_rd_num<=0, fwd_data<=0; counter holds.
  - This includes reg_write=1 with rd_num=0: not committed, not counted.
- retire_count wraps 0xFFFF_FFFF -> 0 with no flag.
- Read ports are combinational on rs_num/rt_num.
  - Index 0 returns 0 regardless of array contents.
  - Both ports may address the same register simultaneously.
- Reset mid-operation: in-flight MEM/WB values in the reset cycle are discarded. The first cycle after reset reads all zeros.
- Commit latency: a write is visible in the array 1 cycle after its posedge (or 0 cycles via bypass, below).

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: write-through bypass. If we=1 and rs_num==rd_num (nonzero), rs_data=wb_data in the same cycle; likewise rt_data. Priority: zero-index > bypass > array.
- Undefined: read ports return array contents only. A same-cycle read of the register being written returns the old value; the hazard unit must stall or forward.

Decomposition:
- Shared package pipeline_pkg: DATA_W and ADDR_W constants; typedefs word_t (DATA_W) and reg_idx_t (ADDR_W); constant REG_ZERO = 0.
- One natural sub-module, regfile_2r1w: the array, zero-register rule, reset clear, 2 combinational read ports, and optional bypass.
- Writeback mux, fwd registers and counter stay in the top.

Test Plan:
- rst 1 cycle, then read rs_num=5, rt_num=31 -> rs_data=0, rt_data=0, retire_count=0, fwd_valid=0.
- reg_write=1, mem_to_reg=0, alu_result=0x1234_5678, rd_num=7, then read rs_num=7 next cycle -> rs_data=0x1234_5678, fwd_valid=1, fwd_rd_num=7, fwd_data=0x1234_5678, retire_count=1.
- reg_write=1, mem_to_reg=1, read_data=0xDEAD_BEEF, alu_result=0x1, rd_num=0 -> r0 still reads 0, fwd_valid=0 next cycle, retire_count unchanged.
- Same cycle: write r9=0xCAFE_0001, rs_num=rt_num=9 -> with WB_BYPASS_EN both reads 0xCAFE_0001; without, both return the prior r9 value (0 after reset).
- Write r3=0xAAAA_AAAA with rst=1 in the same cycle -> r3 reads 0 afterwards, retire_count=0.
- Force retire_count to 0xFFFF_FFFF (back-to-back writes or hierarchical deposit), then one write to r1 -> retire_count=0, r1 updated.
